// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front end with prefetch queue and redirect
module fetch_queue_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    PC_STEP    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [INST_WIDTH-1:0] inst_mem    [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem      [DEPTH];
    logic [ADDR_WIDTH-1:0] inflight_pc [DEPTH];

    ptr_t rd_ptr, wr_ptr, if_rd, if_wr;
    cnt_t count, outstanding, drop;

    logic [CW:0] credits_used;
    logic        resp, push, pop;

    // Credits cover both queued entries and fetches still in flight, so the queue cannot overflow.
    assign credits_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req     = !reset && !redirect && (credits_used < {1'b0, DEPTH_C});
    assign imem_addr    = fetch_pc;

    assign resp       = imem_rvalid && (outstanding != '0);
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect;
    assign push       = resp && (drop == '0) && !redirect;

    assign inst_out = inst_valid ? inst_mem[rd_ptr] : NOP_INST;
    assign inst_pc  = inst_valid ? pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            if_rd       <= '0;
            if_wr       <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
                if_wr    <= if_wr + ptr_t'(1);
            end
            // The in-flight PC FIFO advances on every response, dropped or not, to stay aligned.
            if (resp) begin
                if_rd <= if_rd + ptr_t'(1);
            end
            outstanding <= outstanding + cnt_t'(imem_req) - cnt_t'(resp);
            if (redirect) begin
                fetch_pc <= redirect_addr;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop     <= outstanding - cnt_t'(resp);
            end else begin
                if (resp && (drop != '0)) begin
                    drop <= drop - cnt_t'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            inflight_pc[if_wr] <= fetch_pc;
        end
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= inflight_pc[if_rd];
        end
    end

    // A response with nothing outstanding is a memory-side protocol violation.
    assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit
module tb_fetch_queue_unit;

    localparam logic [31:0] NOP = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;

    logic        imem_req2;
    logic [7:0]  imem_addr2;
    logic        imem_rvalid2 = 1'b0;
    logic [31:0] imem_rdata2 = '0;
    logic        inst_valid2;
    logic [31:0] inst_out2;
    logic [7:0]  inst_pc2;
    logic        inst_ready2 = 1'b1;
    logic        redirect2 = 1'b0;
    logic [7:0]  redirect_addr2 = '0;

    fetch_queue_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_addr(redirect_addr)
    );

    fetch_queue_unit #(
        .ADDR_WIDTH(8), .INST_WIDTH(32), .DEPTH(8), .PC_STEP(4), .RESET_PC(8'hF8)
    ) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .inst_valid(inst_valid2), .inst_out(inst_out2), .inst_pc(inst_pc2),
        .inst_ready(inst_ready2), .redirect(redirect2), .redirect_addr(redirect_addr2)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int fails = 0;

    int          cyc = 0;
    int          lat = 1;
    logic [31:0] mq_a[$];
    int          mq_d[$];

    logic [31:0] pc_m = '0;
    int          cnt_m = 0, out_m = 0, drop_m = 0;
    logic [31:0] sb[$];
    int          n_req = 0, n_acc = 0;

    logic        p2_req = 1'b0;
    logic [7:0]  p2_addr = '0;
    logic [7:0]  pc2_m = 8'hF8;
    int          cnt2_m = 0, n_acc2 = 0, idx2 = 0;
    logic [7:0]  sb2[$];
    logic [7:0]  first4[4];

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic exp_req, exp_v, exp_v2;
        if (reset) begin
            mq_a.delete();
            mq_d.delete();
            imem_rvalid = 1'b0;
        end else if (mq_a.size() > 0 && mq_d[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = f(mq_a.pop_front());
            void'(mq_d.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        imem_rvalid2 = !reset && p2_req;
        imem_rdata2  = f({24'h0, p2_addr});
        #1;
        exp_req = !reset && !redirect && (cnt_m + out_m < 4);
        exp_v   = !reset && (cnt_m != 0);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, pc_m);
        chk("inst_valid", inst_valid, exp_v);
        if (exp_v) begin
            chk("inst_pc", inst_pc, sb[0]);
            chk("inst_out", inst_out, f(sb[0]));
        end else begin
            chk("inst_pc_idle", inst_pc, 32'h0);
            chk("inst_out_nop", inst_out, NOP);
        end
        if (imem_req === 1'b1 && !reset) begin
            mq_a.push_back(imem_addr);
            mq_d.push_back(cyc + lat);
            n_req++;
        end
        if (reset) begin
            pc_m = '0; cnt_m = 0; out_m = 0; drop_m = 0; sb.delete();
        end else if (redirect) begin
            drop_m = out_m - int'(imem_rvalid);
            out_m  = out_m - int'(imem_rvalid);
            cnt_m  = 0;
            sb.delete();
            pc_m   = redirect_addr;
        end else begin
            if (exp_v && inst_ready) begin
                void'(sb.pop_front());
                cnt_m--;
                n_acc++;
            end
            if (imem_rvalid) begin
                out_m--;
                if (drop_m > 0) drop_m--;
                else cnt_m++;
            end
            if (exp_req) begin
                sb.push_back(pc_m);
                out_m++;
                pc_m = pc_m + 32'd4;
            end
        end

        exp_v2 = !reset && (cnt2_m != 0);
        chk("imem_req2", imem_req2, !reset);
        if (!reset) chk("imem_addr2", imem_addr2, pc2_m);
        chk("inst_valid2", inst_valid2, exp_v2);
        if (exp_v2) begin
            chk("inst_pc2", inst_pc2, sb2[0]);
            chk("inst_out2", inst_out2, f({24'h0, sb2[0]}));
        end
        p2_req  = imem_req2 && !reset;
        p2_addr = imem_addr2;
        if (reset) begin
            pc2_m = 8'hF8; cnt2_m = 0; n_acc2 = 0; idx2 = 0; sb2.delete();
        end else begin
            if (exp_v2) begin
                void'(sb2.pop_front());
                cnt2_m--;
                n_acc2++;
            end
            if (imem_rvalid2) cnt2_m++;
            if (idx2 < 4) begin
                first4[idx2] = imem_addr2;
                idx2++;
            end
            sb2.push_back(pc2_m);
            pc2_m = pc2_m + 8'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int k;
        step();
        step();
        reset = 1'b0;

        n_acc = 0;
        repeat (12) step();
        chk("stream_accepts", n_acc, 10);

        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", inst_valid, 1'b0);
        chk("async_rst_nop", inst_out, NOP);
        chk("async_rst_req", imem_req, 1'b0);
        step();
        reset = 1'b0;

        inst_ready = 1'b0;
        n_req = 0;
        repeat (10) step();
        chk("bp_requests", n_req, 4);
        inst_ready = 1'b1;
        repeat (10) step();

        lat = 3;
        k = 0;
        while (out_m != 3 && k < 20) begin
            step();
            k++;
        end
        chk("reach_outstanding3", k < 20, 1'b1);
        redirect = 1'b1;
        redirect_addr = 32'h100;
        step();
        redirect = 1'b0;
        k = 0;
        while (inst_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("redir_wait_bound", k < 20, 1'b1);
        chk("redir_first_pc", inst_pc, 32'h100);

        lat = 1;
        repeat (8) step();
        redirect = 1'b1;
        redirect_addr = 32'h200;
        step();
        redirect = 1'b0;
        #1;
        chk("sim_empty", inst_valid, 1'b0);
        chk("sim_req_after", imem_req, 1'b1);
        chk("sim_addr_after", imem_addr, 32'h200);
        step();
        repeat (3) step();

        redirect = 1'b1;
        redirect_addr = 32'h300;
        step();
        redirect_addr = 32'h400;
        step();
        redirect = 1'b0;
        repeat (6) step();

        repeat (20) step();
        chk("wrap_first0", first4[0], 8'hF8);
        chk("wrap_first1", first4[1], 8'hFC);
        chk("wrap_first2", first4[2], 8'h00);
        chk("wrap_first3", first4[3], 8'h04);
        chk("wrap_pops", n_acc2 >= 12, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
